// File: rtl/key_step_debouncer.sv
// Push-button front end: synchronizes an active-low key and a data switch, debounces the key,
// and emits a one-cycle step strobe (with optional auto-repeat) plus the data bit captured on it.
module key_step_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 0,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic aclr,
    input  logic key_n,
    input  logic w_in,
    output logic step,
    output logic w_out,
    output logic held
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PRESS_DB = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] REL_DB   = 2'd3;

    // Thresholds are compared against the count before it increments, hence the -1.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0] key_sync_reg;
    logic [1:0] w_sync_reg;
    logic       key_s;
    logic       w_s;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (aclr) begin
                        key_sync_reg[gi] <= 1'b0;
                        w_sync_reg[gi]   <= 1'b0;
                    end else begin
                        key_sync_reg[gi] <= ~key_n;
                        w_sync_reg[gi]   <= w_in;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (aclr) begin
                        key_sync_reg[gi] <= 1'b0;
                        w_sync_reg[gi]   <= 1'b0;
                    end else begin
                        key_sync_reg[gi] <= key_sync_reg[gi-1];
                        w_sync_reg[gi]   <= w_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign key_s = key_sync_reg[1];
    assign w_s   = w_sync_reg[1];

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] db_cnt_reg, db_cnt_next;
    logic [CNT_W-1:0] rep_cnt_reg, rep_cnt_next;
    logic             step_reg, step_next;
    logic             w_out_reg, w_out_next;

    always_comb begin
        state_next   = state_reg;
        db_cnt_next  = db_cnt_reg;
        rep_cnt_next = rep_cnt_reg;
        step_next    = 1'b0;
        w_out_next   = w_out_reg;
        case (state_reg)
            IDLE: begin
                if (key_s) begin
                    state_next  = PRESS_DB;
                    db_cnt_next = CNT_ONE;
                end
            end
            PRESS_DB: begin
                if (!key_s) begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else if (db_cnt_reg >= DB_LAST) begin
                    state_next   = HELD;
                    db_cnt_next  = '0;
                    rep_cnt_next = '0;
                    step_next    = 1'b1;
                    w_out_next   = w_s;
                end else begin
                    db_cnt_next = db_cnt_reg + CNT_ONE;
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_next  = REL_DB;
                    db_cnt_next = CNT_ONE;
                end else if (REPEAT_CYCLES > 0) begin
                    if (rep_cnt_reg >= REP_LAST) begin
                        rep_cnt_next = '0;
                        step_next    = 1'b1;
                        w_out_next   = w_s;
                    end else begin
                        rep_cnt_next = rep_cnt_reg + CNT_ONE;
                    end
                end
            end
            REL_DB: begin
                // Repeat count stays frozen here so a short release glitch resumes the cadence.
                if (key_s) begin
                    state_next  = HELD;
                    db_cnt_next = '0;
                end else if (db_cnt_reg >= DB_LAST) begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next   = IDLE;
                db_cnt_next  = '0;
                rep_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_reg   <= IDLE;
            db_cnt_reg  <= '0;
            rep_cnt_reg <= '0;
            step_reg    <= 1'b0;
            w_out_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            db_cnt_reg  <= db_cnt_next;
            rep_cnt_reg <= rep_cnt_next;
            step_reg    <= step_next;
            w_out_reg   <= w_out_next;
        end
    end

    assign step  = step_reg;
    assign w_out = w_out_reg;
    assign held  = (state_reg == HELD) || (state_reg == REL_DB);

endmodule

// File: tb/tb_key_step_debouncer.sv
// Bench for key_step_debouncer: directed latency/boundary scenarios plus randomized key and data
// traffic checked against a run-length reference model, on one non-repeating and one repeating instance.
module tb_key_step_debouncer;

    localparam int DEB = 4;
    localparam int REP = 8;

    logic clk = 1'b0;
    logic aclr, key_n, w_in;
    logic step0, w_out0, held0;
    logic step1, w_out1, held1;

    always #5 clk = ~clk;

    key_step_debouncer #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(0), .CNT_W(8)) dut0 (
        .clk(clk), .aclr(aclr), .key_n(key_n), .w_in(w_in),
        .step(step0), .w_out(w_out0), .held(held0)
    );

    key_step_debouncer #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP), .CNT_W(8)) dut1 (
        .clk(clk), .aclr(aclr), .key_n(key_n), .w_in(w_in),
        .step(step1), .w_out(w_out1), .held(held1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a key level is accepted after DEB consecutive synchronized samples
    // disagreeing with the current level; held time (outside release debounce) drives repeats.
    bit mk1, mk2, mw1, mw2;
    bit lvl[2];
    int run[2];
    int rep[2];
    int rep_lim[2];
    bit m_step[2];
    bit m_wout[2];

    task automatic cycle();
        bit ks, ws;
        @(posedge clk);
        if (aclr) begin
            mk1 = 0; mk2 = 0; mw1 = 0; mw2 = 0;
            for (int i = 0; i < 2; i++) begin
                lvl[i] = 0; run[i] = 0; rep[i] = 0; m_step[i] = 0; m_wout[i] = 0;
            end
        end else begin
            ks = mk2;
            ws = mw2;
            for (int i = 0; i < 2; i++) begin
                m_step[i] = 0;
                if (ks != lvl[i]) begin
                    run[i]++;
                    if (run[i] >= DEB) begin
                        lvl[i] = ks;
                        run[i] = 0;
                        if (ks) begin
                            m_step[i] = 1; m_wout[i] = ws; rep[i] = 0;
                        end
                    end
                end else begin
                    if (lvl[i] && run[i] == 0 && rep_lim[i] > 0) begin
                        rep[i]++;
                        if (rep[i] >= rep_lim[i]) begin
                            m_step[i] = 1; m_wout[i] = ws; rep[i] = 0;
                        end
                    end
                    run[i] = 0;
                end
            end
            mk2 = mk1; mk1 = ~key_n;
            mw2 = mw1; mw1 = w_in;
        end
        @(negedge clk);
    endtask

    task automatic release_key();
        key_n = 1'b1;
        repeat (12) cycle();
    endtask

    task automatic test_reset();
        int first;
        aclr = 1'b1; key_n = 1'b0; w_in = 1'b0;
        repeat (2) begin
            cycle();
            total++;
            if ({step0, held0, w_out0, step1, held1, w_out1} !== 6'b0) begin
                bad++;
                $display("FAIL reset_outputs got step/held/w_out=%b%b%b %b%b%b required all 0",
                         step0, held0, w_out0, step1, held1, w_out1);
            end
        end
        aclr = 1'b0;
        first = 0;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (step0 && first == 0) first = c;
        end
        total++;
        if (first !== DEB + 2) begin
            bad++;
            $display("FAIL reset_first_step got edge %0d required %0d", first, DEB + 2);
        end
        $display("test_reset: first step at edge %0d", first);
    endtask

    task automatic test_clean_press();
        int first, nsteps, rel;
        w_in = 1'b1; key_n = 1'b0;
        first = 0; nsteps = 0;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            if (step0) begin
                nsteps++;
                if (first == 0) first = c;
            end
        end
        total++;
        if (nsteps !== 1) begin
            bad++; $display("FAIL press_step_count got %0d required 1", nsteps);
        end
        total++;
        if (first !== DEB + 2) begin
            bad++; $display("FAIL press_latency got %0d required %0d", first, DEB + 2);
        end
        total++;
        if (w_out0 !== 1'b1 || held0 !== 1'b1) begin
            bad++; $display("FAIL press_wout_held got w_out=%b held=%b required 1 1", w_out0, held0);
        end
        key_n = 1'b1; w_in = 1'b0;
        rel = 0;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (!held0 && rel == 0) rel = c;
        end
        total++;
        if (rel !== DEB + 2) begin
            bad++; $display("FAIL release_latency got %0d required %0d", rel, DEB + 2);
        end
        total++;
        if (w_out0 !== 1'b1) begin
            bad++; $display("FAIL release_wout_hold got %b required 1", w_out0);
        end
        $display("test_clean_press: steps=%0d latency=%0d release=%0d", nsteps, first, rel);
    endtask

    task automatic test_bounce();
        int nsteps, nheld, first;
        w_in = 1'b0;
        nsteps = 0; nheld = 0;
        for (int i = 0; i < 8; i++) begin
            key_n = ((i / 2) % 2) != 0;
            cycle();
            if (step0) nsteps++;
            if (held0) nheld++;
        end
        key_n = 1'b0;
        first = 0;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (step0 && first == 0) first = c;
            if (step0 && first != c) nsteps++;
        end
        total++;
        if (nsteps !== 0 || nheld !== 0) begin
            bad++; $display("FAIL bounce_quiet got extra steps=%0d held cycles=%0d required 0 0", nsteps, nheld);
        end
        total++;
        if (first !== DEB + 2) begin
            bad++; $display("FAIL bounce_latency got %0d required %0d", first, DEB + 2);
        end
        $display("test_bounce: step %0d edges after stable press", first);
    endtask

    task automatic test_release_glitch();
        int nsteps, ndrop;
        nsteps = 0; ndrop = 0;
        for (int c = 0; c < 14; c++) begin
            key_n = (c < 2);
            cycle();
            if (step0) nsteps++;
            if (!held0) ndrop++;
        end
        total++;
        if (nsteps !== 0) begin
            bad++; $display("FAIL glitch_step got %0d steps required 0", nsteps);
        end
        total++;
        if (ndrop !== 0) begin
            bad++; $display("FAIL glitch_held got %0d released cycles required 0", ndrop);
        end
        $display("test_release_glitch: steps=%0d drops=%0d", nsteps, ndrop);
    endtask

    task automatic test_auto_repeat();
        bit wh[41];
        bit exp_step, prev;
        int nsteps;
        key_n = 1'b0; prev = 0; nsteps = 0;
        for (int c = 1; c <= 40; c++) begin
            w_in = 1'($urandom_range(0, 1));
            wh[c] = w_in;
            cycle();
            exp_step = (c >= DEB + 2) && (((c - (DEB + 2)) % REP) == 0);
            total++;
            if (step1 !== exp_step) begin
                bad++; $display("FAIL repeat_step edge %0d got %b required %b", c, step1, exp_step);
            end
            if (exp_step) begin
                nsteps++;
                total++;
                if (w_out1 !== wh[c-2]) begin
                    bad++; $display("FAIL repeat_wout edge %0d got %b required %b", c, w_out1, wh[c-2]);
                end
            end
            if (prev && step1) begin
                bad++; total++;
                $display("FAIL repeat_width edge %0d got two-cycle step required single", c);
            end
            prev = step1;
        end
        $display("test_auto_repeat: %0d repeat steps expected", nsteps);
    endtask

    task automatic test_reset_mid_hold();
        int first;
        w_in = 1'b1; key_n = 1'b0;
        repeat (10) cycle();
        total++;
        if (held0 !== 1'b1 || w_out0 !== 1'b1) begin
            bad++; $display("FAIL midhold_pre got held=%b w_out=%b required 1 1", held0, w_out0);
        end
        aclr = 1'b1;
        cycle();
        total++;
        if (held0 !== 1'b0 || w_out0 !== 1'b0 || step0 !== 1'b0) begin
            bad++; $display("FAIL midhold_reset got held=%b w_out=%b step=%b required 0 0 0", held0, w_out0, step0);
        end
        aclr = 1'b0;
        first = 0;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (step0 && first == 0) first = c;
        end
        total++;
        if (first !== DEB + 2) begin
            bad++; $display("FAIL midhold_restep got %0d required %0d", first, DEB + 2);
        end
        $display("test_reset_mid_hold: new step at edge %0d", first);
    endtask

    task automatic test_random();
        logic [1:0] st, hd, wo, prev;
        int left;
        prev = 2'b00; left = 0;
        for (int c = 0; c < 800; c++) begin
            if (left == 0) begin
                key_n = 1'($urandom_range(0, 1));
                left  = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 6);
            end
            left--;
            w_in = 1'($urandom_range(0, 1));
            aclr = ($urandom_range(0, 199) == 0);
            cycle();
            st = {step1, step0}; hd = {held1, held0}; wo = {w_out1, w_out0};
            for (int i = 0; i < 2; i++) begin
                total++;
                if (st[i] !== m_step[i] || hd[i] !== lvl[i] || wo[i] !== m_wout[i]) begin
                    bad++;
                    $display("FAIL random dut%0d cyc %0d got step/held/w_out=%b%b%b required %b%b%b",
                             i, c, st[i], hd[i], wo[i], m_step[i], lvl[i], m_wout[i]);
                end
                if (prev[i] && st[i]) begin
                    total++; bad++;
                    $display("FAIL random_width dut%0d cyc %0d got two-cycle step required single", i, c);
                end
            end
            prev = st;
        end
        aclr = 1'b0;
        $display("test_random: 800 cycles compared");
    endtask

    initial begin
        rep_lim[0] = 0;
        rep_lim[1] = REP;
        aclr = 1'b1; key_n = 1'b1; w_in = 1'b0;
        test_reset();
        release_key();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        release_key();
        test_auto_repeat();
        release_key();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
